// File: rtl/next_pc_ras_unit.sv
// Next-PC select with a circular return-address stack.
// Tracks return-prediction hit/miss status and saturating counters.
module next_pc_ras_unit #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             flush,
    input  logic [1:0]       pcsrc,
    input  logic             branch_taken,
    input  logic             is_jal,
    input  logic             is_ret,
    input  logic [PC_W-1:0]  pc_plus4,
    input  logic [PC_W-1:0]  br_target,
    input  logic [PC_W-1:0]  j_target,
    input  logic [PC_W-1:0]  jr_target,
    output logic [PC_W-1:0]  next_pc,
    output logic [PC_W-1:0]  ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             mispredict,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] SAT = '1;

    typedef enum logic [1:0] {
        NORM = 2'b00,
        BRAN = 2'b01,
        PCJR = 2'b10,
        PCJ  = 2'b11
    } pcsrc_t;

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             misp_q, misp_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic             valid, push, pop, hit;

    always_comb begin
        next_pc = pc_plus4;
        unique case (pcsrc_t'(pcsrc))
            NORM:    next_pc = pc_plus4;
            BRAN:    next_pc = branch_taken ? br_target : pc_plus4;
            PCJR:    next_pc = jr_target;
            PCJ:     next_pc = j_target;
            default: next_pc = pc_plus4;
        endcase
    end

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CMAX);
    assign ras_top   = ras_empty ? '0 : ras_q[ptr_q];

    assign valid = en & ~flush;
    assign push  = valid & is_jal;
    assign pop   = valid & is_ret & (pcsrc == PCJR);
    assign hit   = ~ras_empty & (ras_top == jr_target);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        misp_d = 1'b0;
        hit_d  = hit_q;
        miss_d = miss_q;
        // An empty stack has no top to replace, so push+pop falls back to a push
        if (push && (!pop || ras_empty)) begin
            ptr_d  = ptr_q + PONE;
            wr_en  = 1'b1;
            wr_idx = ptr_q + PONE;
            if (!ras_full) cnt_d = cnt_q + CONE;
        end else if (push && pop) begin
            wr_en = 1'b1;
        end else if (pop && !ras_empty) begin
            ptr_d = ptr_q - PONE;
            cnt_d = cnt_q - CONE;
        end
        if (pop) begin
            misp_d = ~hit;
            if (hit) begin
                if (hit_q != SAT) hit_d = hit_q + 1'b1;
            end else begin
                if (miss_q != SAT) miss_d = miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            misp_q <= 1'b0;
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (wr_en) ras_q[wr_idx] <= pc_plus4;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            misp_q <= misp_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign mispredict = misp_q;
    assign hit_cnt    = hit_q;
    assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_next_pc_ras_unit.sv
// Bench for next_pc_ras_unit: scoreboard of expected return outcomes.
// Narrow counters keep the saturation scenario short.
module tb_next_pc_ras_unit;

    localparam int PC_W  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic CLK = 1'b0;
    logic nRST;
    logic en, flush, branch_taken, is_jal, is_ret;
    logic [1:0] pcsrc;
    logic [PC_W-1:0] pc_plus4, br_target, j_target, jr_target;
    logic [PC_W-1:0] next_pc, ras_top;
    logic ras_empty, ras_full, mispredict;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // expected mispredict per issued return, plus model counters
    logic exp_q[$];
    logic [CNT_W-1:0] exp_hit = '0;
    logic [CNT_W-1:0] exp_miss = '0;

    next_pc_ras_unit #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .pcsrc(pcsrc),
        .branch_taken(branch_taken), .is_jal(is_jal), .is_ret(is_ret),
        .pc_plus4(pc_plus4), .br_target(br_target), .j_target(j_target),
        .jr_target(jr_target), .next_pc(next_pc), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full), .mispredict(mispredict),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic e, input logic f, input logic [1:0] ps,
                         input logic j, input logic r,
                         input logic [PC_W-1:0] p4, input logic [PC_W-1:0] jt);
        @(negedge CLK);
        en = e; flush = f; pcsrc = ps; is_jal = j; is_ret = r;
        pc_plus4 = p4; jr_target = jt;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_ret(input logic h);
        exp_q.push_back(~h);
        if (h) begin
            if (exp_hit != '1) exp_hit = exp_hit + 1'b1;
        end else begin
            if (exp_miss != '1) exp_miss = exp_miss + 1'b1;
        end
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        en = 1'b1; is_jal = 1'b1; pcsrc = 2'b11; pc_plus4 = 32'h55;
        #2 nRST = 1'b0;
        @(posedge CLK);
        #1;
        n_chk++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_top !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stack: empty=%b full=%b top=%h, need 1 0 0",
                     ras_empty, ras_full, ras_top);
        end
        n_chk++;
        if (hit_cnt !== '0 || miss_cnt !== '0 || mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: hit=%0d miss=%0d misp=%b, need 0 0 0",
                     hit_cnt, miss_cnt, mispredict);
        end
        @(negedge CLK);
        is_jal = 1'b0; pcsrc = 2'b00;
        nRST = 1'b1;
        idle();
        n_chk++;
        if (ras_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: empty=%b, need 1", ras_empty);
        end
    endtask

    task automatic test_pcsrc();
        logic [1:0] ps [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic bt [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [PC_W-1:0] exp [4] = '{32'h104, 32'h200, 32'h400, 32'h300};
        @(negedge CLK);
        pc_plus4 = 32'h104; br_target = 32'h200;
        j_target = 32'h300; jr_target = 32'h400;
        for (int i = 0; i < 4; i++) begin
            pcsrc = ps[i]; branch_taken = bt[i];
            en = i[0]; flush = i[1];
            #1;
            n_chk++;
            if (next_pc !== exp[i]) begin
                n_fail++;
                $display("FAIL pcsrc_%0d: next_pc=%h, need %h", i, next_pc, exp[i]);
            end
        end
        branch_taken = 1'b0;
        idle();
    endtask

    task automatic test_jal_ret();
        logic m;
        drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h108, 32'h0);
        n_chk++;
        if (ras_top !== 32'h108) begin
            n_fail++;
            $display("FAIL jal_push: top=%h, need 108", ras_top);
        end
        expect_ret(1'b1);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h108);
        m = exp_q.pop_front();
        n_chk++;
        if (mispredict !== m || hit_cnt !== exp_hit || ras_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_ret: misp=%b hit=%0d empty=%b, need %b %0d 1",
                     mispredict, hit_cnt, ras_empty, m, exp_hit);
        end
    endtask

    task automatic test_depth();
        logic m;
        for (int i = 1; i <= 5; i++)
            drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, PC_W'(i * 16), 32'h0);
        n_chk++;
        if (ras_full !== 1'b1 || ras_top !== 32'h50) begin
            n_fail++;
            $display("FAIL depth_full: full=%b top=%h, need 1 50", ras_full, ras_top);
        end
        for (int i = 5; i >= 1; i--) begin
            expect_ret(i > 1);
            drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, PC_W'(i * 16));
            m = exp_q.pop_front();
            n_chk++;
            if (mispredict !== m || hit_cnt !== exp_hit || miss_cnt !== exp_miss) begin
                n_fail++;
                $display("FAIL depth_pop_%0d: misp=%b hit=%0d miss=%0d, need %b %0d %0d",
                         i, mispredict, hit_cnt, miss_cnt, m, exp_hit, exp_miss);
            end
        end
        n_chk++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            n_fail++;
            $display("FAIL depth_empty: empty=%b full=%b, need 1 0", ras_empty, ras_full);
        end
        idle();
        n_chk++;
        if (mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL misp_clear: misp=%b, need 0", mispredict);
        end
    endtask

    task automatic test_push_pop();
        logic m;
        drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h20, 32'h0);
        expect_ret(1'b1);
        drive(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 32'h90, 32'h20);
        m = exp_q.pop_front();
        n_chk++;
        if (ras_top !== 32'h90 || mispredict !== m || hit_cnt !== exp_hit) begin
            n_fail++;
            $display("FAIL push_pop: top=%h misp=%b hit=%0d, need 90 %b %0d",
                     ras_top, mispredict, hit_cnt, m, exp_hit);
        end
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 32'hAA, 32'h0);
        drive(1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'hBB, 32'h0);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h90);
        n_chk++;
        if (ras_top !== 32'h90 || hit_cnt !== exp_hit || miss_cnt !== exp_miss
            || mispredict !== 1'b0) begin
            n_fail++;
            $display("FAIL gated: top=%h hit=%0d miss=%0d misp=%b, need 90 %0d %0d 0",
                     ras_top, hit_cnt, miss_cnt, mispredict, exp_hit, exp_miss);
        end
        expect_ret(1'b1);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h90);
        m = exp_q.pop_front();
        n_chk++;
        if (ras_top !== 32'h10 || mispredict !== m || ras_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_after_replace: top=%h misp=%b empty=%b, need 10 %b 0",
                     ras_top, mispredict, ras_empty, m);
        end
        expect_ret(1'b0);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h44);
        m = exp_q.pop_front();
        n_chk++;
        if (mispredict !== m || miss_cnt !== exp_miss || ras_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrong_target: misp=%b miss=%0d empty=%b, need %b %0d 1",
                     mispredict, miss_cnt, ras_empty, m, exp_miss);
        end
    endtask

    task automatic test_saturation();
        logic m;
        for (int i = 0; i < 20; i++) begin
            expect_ret(1'b0);
            drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0);
            m = exp_q.pop_front();
            if (mispredict !== m) begin
                n_fail++;
                $display("FAIL sat_misp_%0d: misp=%b, need %b", i, mispredict, m);
            end
        end
        n_chk++;
        if (miss_cnt !== exp_miss || exp_miss !== 4'hF) begin
            n_fail++;
            $display("FAIL saturation: miss=%0d, need %0d", miss_cnt, exp_miss);
        end
        n_chk++;
        if (ras_empty !== 1'b1 || hit_cnt !== exp_hit) begin
            n_fail++;
            $display("FAIL sat_side: empty=%b hit=%0d, need 1 %0d",
                     ras_empty, hit_cnt, exp_hit);
        end
        idle();
    endtask

    initial begin
        nRST = 1'b0;
        en = 1'b0; flush = 1'b0; pcsrc = 2'b00; branch_taken = 1'b0;
        is_jal = 1'b0; is_ret = 1'b0;
        pc_plus4 = '0; br_target = '0; j_target = '0; jr_target = '0;
        #12 nRST = 1'b1;
        test_reset();
        test_pcsrc();
        test_jal_ret();
        test_depth();
        test_push_pop();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
